// File: rtl/cost_table.sv
// cost_table: N x N worker/job cost table, filled row-major over a valid/ready
// stream, then read through a registered lookup port with one cycle of latency.
// Optional build macro COST_CLAMP_EN: clamp stored words to MAX_COST and add a
// sticky range_err output.
//
// Ports:
//   CLK, RST     clock (rising edge) and asynchronous active-high reset
//   in_valid     loader presents in_data this cycle
//   in_data      cost word to store
//   in_ready     high only while loading
//   reload       single-cycle request to restart the fill from address 0
//   table_ready  all N*N entries loaded, lookups valid
//   W, J         worker / job index for lookup
//   Cost         registered lookup result (0 unless table_ready)
//   range_err    (COST_CLAMP_EN only) sticky: an accepted word exceeded MAX_COST
module cost_table #(
  parameter int unsigned MAX_COST = 100,
  parameter int unsigned N        = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  input  logic [6:0]             in_data,
  output logic                   in_ready,
  input  logic                   reload,
  output logic                   table_ready,
  input  logic [$clog2(N)-1:0]   W,
  input  logic [$clog2(N)-1:0]   J,
  output logic [6:0]             Cost
`ifdef COST_CLAMP_EN
  ,
  output logic                   range_err
`endif
);

  // N must be a power of two so that {W, J} equals W*N + J.
  localparam int unsigned IDX_W  = $clog2(N);
  localparam int unsigned ADDR_W = 2 * IDX_W;
  localparam int unsigned DEPTH  = N * N;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_READY
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [6:0]          r_mem [DEPTH];
  logic [6:0]          r_cost;

  logic                w_xfer;
  logic                w_last;
  logic                w_reload_act;
  logic [6:0]          w_wr_data;
  logic [ADDR_W-1:0]   w_rd_addr;

  assign in_ready    = (r_state == S_LOAD);
  assign table_ready = (r_state == S_READY);

  // A reload in LOAD wins over a simultaneous transfer: the word is dropped.
  assign w_xfer       = in_valid & in_ready & ~reload;
  assign w_reload_act = reload & (r_state != S_IDLE);
  assign w_last       = (r_wr_addr == ADDR_W'(DEPTH - 1));
  assign w_rd_addr    = {W, J};

`ifdef COST_CLAMP_EN
  localparam logic [6:0] LP_MAX_COST = 7'(MAX_COST);

  logic w_over;
  logic r_range_err;

  assign w_over    = (in_data > LP_MAX_COST);
  assign w_wr_data = w_over ? LP_MAX_COST : in_data;
  assign range_err = r_range_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_range_err <= 1'b0;
    end else if (w_reload_act) begin
      r_range_err <= 1'b0;
    end else if (w_xfer && w_over) begin
      r_range_err <= 1'b1;
    end
  end
`else
  assign w_wr_data = in_data;
`endif

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = S_LOAD;
      S_LOAD:  if (w_xfer && w_last) w_next_state = S_READY;
      S_READY: if (reload) w_next_state = S_LOAD;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Write pointer wraps naturally from DEPTH-1 to 0 on the final transfer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_addr <= '0;
    end else if (w_reload_act) begin
      r_wr_addr <= '0;
    end else if (w_xfer) begin
      r_wr_addr <= r_wr_addr + ADDR_W'(1);
    end
  end

  // Table storage carries no reset; contents are undefined until loaded.
  always_ff @(posedge CLK) begin
    if (w_xfer) begin
      r_mem[r_wr_addr] <= w_wr_data;
    end
  end

  // Lookup register; forced to 0 outside READY and on the reload edge so that
  // Cost is already 0 in the first LOAD cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cost <= '0;
    end else if ((r_state == S_READY) && !reload) begin
      r_cost <= r_mem[w_rd_addr];
    end else begin
      r_cost <= '0;
    end
  end

  assign Cost = r_cost;

endmodule
